// File: rtl/shift_arb_pkg.sv
// Shared types, widths and lane-select helpers for the shift arbiter.
// Latency: none (declarations only).
// Backpressure: n/a. Optional rotate support is guarded by SHIFT_ARB_ROTATE_EN.
package shift_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    // Lane helpers work on buses sized for the largest supported requester count.
    localparam int MAX_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0
`ifdef SHIFT_ARB_ROTATE_EN
        , S_ROT2 = 1'b1
`endif
    } shift_arb_state_t;

    // Pick requester idx's operand out of a packed, zero-extended data bus.
    function automatic logic [DATA_W-1:0] sel_data(input logic [MAX_REQ*DATA_W-1:0] bus,
                                                   input logic [SEL_W-1:0] idx);
        return bus[idx*DATA_W +: DATA_W];
    endfunction

    // Pick requester idx's shift amount out of a packed, zero-extended amount bus.
    function automatic logic [SHAMT_W-1:0] sel_shamt(input logic [MAX_REQ*SHAMT_W-1:0] bus,
                                                     input logic [SEL_W-1:0] idx);
        return bus[idx*SHAMT_W +: SHAMT_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] pos;

    // Walk N positions starting from ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = '0;
        for (int i = 0; i < N; i++) begin
            pos = IW'((int'(ptr) + i) % N);
            if (!grant_any && req[pos]) begin
                grant_any  = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin front end time-sharing one logical barrel shifter (rotate option: SHIFT_ARB_ROTATE_EN).
// Latency: 1 cycle per shift; 2 cycles per rotate with nonzero amount.
// Backpressure: no grant while the response register is full and not being popped, or mid-rotate.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt_i,
    input  logic [NUM_REQ-1:0]         req_right_i,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic [NUM_REQ-1:0]         req_rotate_i,
`endif
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_rsp_valid,
    output logic [DATA_W-1:0]          o_rsp_data,
    output logic [ID_W-1:0]            o_rsp_id,
    input  logic                       rsp_ready_i
);

    shift_arb_state_t state;
    logic [ID_W-1:0]  ptr;

    logic [NUM_REQ-1:0]         grant;
    logic [ID_W-1:0]            win_idx;
    logic                       win_any;
    logic [SEL_W-1:0]           win_sel;
    logic [DATA_W-1:0]          win_data;
    logic [SHAMT_W-1:0]         win_shamt;
    logic                       win_right;
    logic [MAX_REQ*DATA_W-1:0]  data_ext;
    logic [MAX_REQ*SHAMT_W-1:0] shamt_ext;

    logic free, accept_ok, accept;

    logic [DATA_W-1:0]  sh_data, sh_out;
    logic [SHAMT_W-1:0] sh_amt;
    logic               sh_right;

`ifdef SHIFT_ARB_ROTATE_EN
    // Pass-1 result plus everything pass 2 needs, since the requester may move on after grant.
    logic [DATA_W-1:0]  rot_part;
    logic [DATA_W-1:0]  rot_data;
    logic [SHAMT_W-1:0] rot_shamt;
    logic               rot_right;
    logic [ID_W-1:0]    rot_id;
    logic               win_rot;
    assign win_rot = req_rotate_i[win_idx];
`endif

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
        .req       (req_valid_i),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    // Zero-extend the request buses so the lane helpers see a fixed width.
    always_comb begin
        data_ext  = '0;
        shamt_ext = '0;
        data_ext[NUM_REQ*DATA_W-1:0]   = req_data_i;
        shamt_ext[NUM_REQ*SHAMT_W-1:0] = req_shamt_i;
    end

    assign win_sel   = SEL_W'(win_idx);
    assign win_data  = sel_data(data_ext, win_sel);
    assign win_shamt = sel_shamt(shamt_ext, win_sel);
    assign win_right = req_right_i[win_idx];

    assign free        = !o_rsp_valid || rsp_ready_i;
    assign accept_ok   = (state == S_IDLE) && !rst_i && free;
    assign accept      = accept_ok && win_any;
    assign o_req_ready = accept_ok ? grant : '0;

    // Steer the shared shifter: winner on accept, pass 2 while rotating, zeros otherwise.
    always_comb begin
        sh_data  = '0;
        sh_amt   = '0;
        sh_right = 1'b0;
        if (accept) begin
            sh_data  = win_data;
            sh_amt   = win_shamt;
            sh_right = win_right;
        end
`ifdef SHIFT_ARB_ROTATE_EN
        else if (state == S_ROT2) begin
            sh_data  = rot_data;
            sh_amt   = (~rot_shamt) + SHAMT_W'(1);  // 32 - s, s known nonzero
            sh_right = !rot_right;
        end
`endif
    end

    // The single logical shifter instance, zero fill in both directions.
    always_comb begin
        sh_out = sh_right ? (sh_data >> sh_amt) : (sh_data << sh_amt);
    end

    // Pointer, FSM and response register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            ptr         <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= '0;
`ifdef SHIFT_ARB_ROTATE_EN
            rot_part    <= '0;
            rot_data    <= '0;
            rot_shamt   <= '0;
            rot_right   <= 1'b0;
            rot_id      <= '0;
`endif
        end else begin
            if (accept) begin
                ptr <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
            end
`ifdef SHIFT_ARB_ROTATE_EN
            if (state == S_ROT2) begin
                // Stay here with the partial held until the output register can take the result.
                if (free) begin
                    o_rsp_valid <= 1'b1;
                    o_rsp_data  <= rot_part | sh_out;
                    o_rsp_id    <= rot_id;
                    state       <= S_IDLE;
                end
            end else if (accept && win_rot && (win_shamt != '0)) begin
                rot_part  <= sh_out;
                rot_data  <= win_data;
                rot_shamt <= win_shamt;
                rot_right <= win_right;
                rot_id    <= win_idx;
                state     <= S_ROT2;
                if (rsp_ready_i) begin
                    o_rsp_valid <= 1'b0;
                end
            end else
`endif
            if (accept) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= sh_out;
                o_rsp_id    <= win_idx;
            end else if (rsp_ready_i) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shared-resource controller that lets `NUM_REQ` independent requesters time-share one 32-bit logical barrel shifter. It grants requests round-robin over a valid/ready handshake and drives the shifter's data, amount and direction inputs from the winner. The result is registered with the winner's ID and returned over a valid/ready response channel. It sits between the shift-issuing clients and the single combinational shifter instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the response ID; derived, not overridden.

- `clk_i`  in  1: single clock, rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ: per-requester request valid.
- `req_data_i`  in  NUM_REQ*32: operand; requester k occupies bits [32k+31:32k].
- `req_shamt_i`  in  NUM_REQ*5: shift amount 0..31, packed the same way.
- `req_right_i`  in  NUM_REQ: direction; 1 = logical right, 0 = logical left.
- `o_req_ready`  out  NUM_REQ: one-hot grant; a request transfers when valid and ready are both 1.
- `o_rsp_valid`  out  1: response holds a result.
- `o_rsp_data`  out  32: shifted result.
- `o_rsp_id`  out  ID_W: index of the requester that produced the result.
- `rsp_ready_i`  in  1: consumer accepts the response.

## Operation
- Shifts are logical with zero fill: right gives `data >> s`, left gives `(data << s)[31:0]`.
- FSM states:
  - `S_IDLE`: accepts requests.
  - `S_ROT2`: second shifter pass. Exists only with the rotate feature.
- Accept condition: state is `S_IDLE`, `rst_i` = 0, and the output register is free.
  - "Free" means `!o_rsp_valid || rsp_ready_i`.
- Arbitration:
  - Search starts at pointer `ptr` and wraps modulo `NUM_REQ`.
  - The first requester with valid = 1 wins and its `o_req_ready` bit is driven high.
  - Ready is never asserted to a requester whose valid is 0.
  - Ready is all-zero when there is no winner or the accept condition is false.
- On accept of requester k:
  - `ptr` becomes `(k+1) mod NUM_REQ`.
  - The result is loaded into `o_rsp_data` and `o_rsp_id` = k.
  - `o_rsp_valid` is set to 1.
- Output register:
  - Holds its value while `o_rsp_valid && !rsp_ready_i`.
  - Clears `o_rsp_valid` on `rsp_ready_i` unless a new result loads in the same cycle.
- Simultaneous pop and accept in one cycle gives back-to-back throughput of one result per cycle.
- Requesters hold data, amount and direction stable from valid until the handshake. The block does not latch a request before grant.
- Dropping valid before ready is legal: the request is withdrawn and `ptr` is unchanged.
- Idle shifter inputs are driven to zero.

## Timing
- Reset values: `o_rsp_valid` = 0, `o_rsp_data` = 0, `o_rsp_id` = 0, `ptr` = 0, state `S_IDLE`, `o_req_ready` = 0.
- Reset mid-operation: discards any in-flight rotate and any pending response. A request presented during reset is not accepted.
- Latency for a shift: handshake at edge N, so `o_rsp_valid` = 1 after edge N (1 cycle).
- Latency for a rotate with amount s ≠ 0: handshake at edge N, then `S_ROT2` for one cycle, so `o_rsp_valid` = 1 after edge N+1.
  - `o_req_ready` is all-zero while in `S_ROT2`.
- Stalled rotate: if the output register is not free in `S_ROT2`, the block stays in `S_ROT2` with the partial result held.
- Fairness: a continuously valid requester is granted within `NUM_REQ` accepts.

## Configuration
- Macro: `SHIFT_ARB_ROTATE_EN`.
- Defined:
  - Adds port `req_rotate_i`  in  NUM_REQ, the per-requester rotate select.
  - A rotate request uses two shifter passes and ORs them:
    - pass 1 uses amount s in the requested direction;
    - pass 2 uses amount `32 - s` in the opposite direction.
  - s = 0 skips pass 2 and returns the operand in 1 cycle.
  - `S_ROT2` and a 32-bit partial-result register exist.
- Undefined:
  - The port, `S_ROT2` and the partial-result register are absent.
  - All requests are single-pass shifts.

## Structure
- Package `shift_arb_pkg` holds:
  - `DATA_W` = 32 and `SHAMT_W` = 5;
  - the FSM state enum `shift_arb_state_t`;
  - the function that selects a requester's slice from a packed bus.
- Sub-module `rr_arbiter`: request vector plus pointer in, one-hot grant plus index out, purely combinational.
- The shifter is instantiated once inside `shift_arbiter`.

## Test plan
- Single request, `rsp_ready_i` = 1: requester 0 sends 0xA5A5A5A5, right 4 → one cycle later `o_rsp_data` = 0x0A5A5A5A, `o_rsp_id` = 0. The same operand left 4 gives 0x5A5A5A50.
- All four requesters valid continuously with 0x12345678 and shift 5:
  - requesters 0 and 2 shift left and return 0x468ACF00;
  - requesters 1 and 3 shift right and return 0x0091A2B3;
  - grants occur in order 0,1,2,3,0 with one response per cycle.
- Backpressure: hold `rsp_ready_i` = 0 for 5 cycles with a response pending.
  - `o_rsp_data` and `o_rsp_id` are stable and `o_req_ready` is all-zero.
  - On release, the held response pops and a new grant issues in the same cycle.
- Reset mid-stream: assert `rst_i` with a response pending and all requesters valid → next cycle `o_rsp_valid` = 0 and ready is 0. After release, the first grant goes to requester 0.
- With `SHIFT_ARB_ROTATE_EN`:
  - 0x12345678 rotate right 8 → 0x78123456 after 2 cycles, with ready all-zero during `S_ROT2`;
  - rotate left 31 → 0x091A2B3C;
  - rotate with s = 0 → 0x12345678 after 1 cycle.
- Withdrawal: requester 1 drops valid before being granted → no response carries ID 1 and `ptr` is unaffected.
